// File: rtl/reg_rd_alt.sv
// reg_rd_alt: small FIFO whose read side steers popped words alternately
// to dout1 then dout2 (1-cycle read latency, registered outputs).
// Optional build macro REG_RD_ERR_FLAG_EN adds err_clr input and sticky
// ovf/udf error flags; without it, dropped writes and empty reads are silent.
module reg_rd_alt #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout1,
    output logic [WIDTH-1:0]         dout2,
    output logic                     vld1,
    output logic                     vld2,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
`ifdef REG_RD_ERR_FLAG_EN
    ,
    input  logic                     err_clr,
    output logic                     ovf,
    output logic                     udf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {SEL1, SEL2} sel_t;

    sel_t             state, next_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             rd_acc, wr_acc;
    logic             ld1, ld2;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign wr_ready = ~full | rd_en;
    assign rd_acc   = rd_en & ~empty;
    // Full + read frees the head slot this edge, so the write may land.
    assign wr_acc   = wr_en & (~full | rd_acc);

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wp] <= wr_data;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_acc)
                wp <= wp + AW'(1);
            if (rd_acc)
                rp <= rp + AW'(1);
            if (wr_acc && !rd_acc)
                count <= count + CW'(1);
            else if (rd_acc && !wr_acc)
                count <= count - CW'(1);
        end
    end

    // Steering state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= SEL1;
        else
            state <= next_state;
    end

    // Next-state and output-load selection; toggles only on an accepted read.
    always_comb begin
        next_state = state;
        ld1        = 1'b0;
        ld2        = 1'b0;
        if (rd_acc) begin
            case (state)
                SEL1: begin
                    ld1        = 1'b1;
                    next_state = SEL2;
                end
                SEL2: begin
                    ld2        = 1'b1;
                    next_state = SEL1;
                end
                default: next_state = SEL1;
            endcase
        end
    end

    // Output data registers and one-cycle valid pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout1 <= '0;
            dout2 <= '0;
            vld1  <= 1'b0;
            vld2  <= 1'b0;
        end else begin
            vld1 <= ld1;
            vld2 <= ld2;
            if (ld1)
                dout1 <= mem[rp];
            if (ld2)
                dout2 <= mem[rp];
        end
    end

`ifdef REG_RD_ERR_FLAG_EN
    logic ovf_set, udf_set;
    assign ovf_set = wr_en & full & ~rd_en;
    assign udf_set = rd_en & empty;

    // Sticky error flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_set)
                ovf <= 1'b1;
            else if (err_clr)
                ovf <= 1'b0;
            if (udf_set)
                udf <= 1'b1;
            else if (err_clr)
                udf <= 1'b0;
        end
    end
`endif

endmodule
